// File: rtl/segment_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : segment_mux_if
// Description : Display bus between the timer datapath and segment_mux.
//               Carries the value to show, the 1 Hz blink level and the
//               active-low anode/cathode drive for the board pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface segment_mux_if;
  logic        CLK1Hz;
  logic [15:0] bcd_num;
  logic [3:0]  an;
  logic [7:0]  segment;

  // Producer side: supplies value and blink level, observes the pins
  modport master (
    output CLK1Hz,
    output bcd_num,
    input  an,
    input  segment
  );

  // Display driver side
  modport slave (
    input  CLK1Hz,
    input  bcd_num,
    output an,
    output segment
  );
endinterface
`default_nettype wire

// File: rtl/segment_mux.sv
`default_nettype none
// ============================================================================
// Module      : segment_mux
// Description : 4-digit multiplexed common-anode 7-segment driver. Scans one
//               digit per clk500hz cycle, decodes its nibble to a hex glyph,
//               optionally blanks leading zeros and blinks one decimal point
//               from the synchronized 1 Hz level.
// Revision    : 1.0 - initial release
// ============================================================================
module segment_mux #(
  parameter int DP_DIGIT = 2,
  parameter bit LZB      = 1'b0
) (
  input  wire logic       clk500hz,
  input  wire logic       rstn,
  segment_mux_if.slave    disp
);

  localparam logic [1:0] c_dp_digit = DP_DIGIT[1:0];

  logic [1:0] r_k;
  logic       r_dp_meta;
  logic       r_dp_s;
  logic [3:0] r_an;
  logic [7:0] r_seg;

  logic [3:0] w_nibble;
  logic [6:0] w_glyph;
  logic       w_z3;
  logic       w_z32;
  logic       w_z321;
  logic       w_blank;
  logic [7:0] w_seg;

  // Two-flop synchronizer bringing the 1 Hz blink level into the scan domain
  always_ff @(posedge clk500hz or negedge rstn) begin
    if (!rstn) begin
      r_dp_meta <= 1'b0;
      r_dp_s    <= 1'b0;
    end else begin
      r_dp_meta <= disp.CLK1Hz;
      r_dp_s    <= r_dp_meta;
    end
  end

  // Select the nibble of the digit being loaded and decide its segment pattern
  always_comb begin
    w_nibble = 4'h0;
    w_glyph  = 7'h7F;
    w_blank  = 1'b0;
    w_seg    = 8'hFF;

    case (r_k)
      2'd0:    w_nibble = disp.bcd_num[3:0];
      2'd1:    w_nibble = disp.bcd_num[7:4];
      2'd2:    w_nibble = disp.bcd_num[11:8];
      default: w_nibble = disp.bcd_num[15:12];
    endcase

    // Active-low {g,f,e,d,c,b,a}
    case (w_nibble)
      4'h0:    w_glyph = 7'h40;
      4'h1:    w_glyph = 7'h79;
      4'h2:    w_glyph = 7'h24;
      4'h3:    w_glyph = 7'h30;
      4'h4:    w_glyph = 7'h19;
      4'h5:    w_glyph = 7'h12;
      4'h6:    w_glyph = 7'h02;
      4'h7:    w_glyph = 7'h78;
      4'h8:    w_glyph = 7'h00;
      4'h9:    w_glyph = 7'h10;
      4'hA:    w_glyph = 7'h08;
      4'hB:    w_glyph = 7'h03;
      4'hC:    w_glyph = 7'h46;
      4'hD:    w_glyph = 7'h21;
      4'hE:    w_glyph = 7'h06;
      default: w_glyph = 7'h0E;
    endcase

    // A digit is a leading zero only if it and every digit to its left are zero;
    // digit0 is always shown so a zero value still reads "0".
    case (r_k)
      2'd3:    w_blank = w_z3;
      2'd2:    w_blank = w_z32;
      2'd1:    w_blank = w_z321;
      default: w_blank = 1'b0;
    endcase
    w_blank = w_blank & LZB;

    w_seg[6:0] = w_blank ? 7'h7F : w_glyph;
    w_seg[7]   = (r_k == c_dp_digit) ? ~r_dp_s : 1'b1;
  end

  assign w_z3   = (disp.bcd_num[15:12] == 4'h0);
  assign w_z32  = w_z3  && (disp.bcd_num[11:8] == 4'h0);
  assign w_z321 = w_z32 && (disp.bcd_num[7:4]  == 4'h0);

  // Scan register: load the pins for the current digit, then advance to the next
  always_ff @(posedge clk500hz or negedge rstn) begin
    if (!rstn) begin
      r_k   <= 2'd0;
      r_an  <= 4'hF;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= ~(4'b0001 << r_k);
      r_seg <= w_seg;
      r_k   <= r_k + 2'd1;
    end
  end

  assign disp.an      = r_an;
  assign disp.segment = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_segment_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_segment_mux
// Description : Scoreboard bench for segment_mux. Two instances (leading-zero
//               blanking off and on) share clock, reset and inputs; a reference
//               model predicts each scan slot and a monitor compares the pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segment_mux;

  localparam int DP_DIGIT = 2;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg0;
    logic [7:0] seg1;
  } exp_t;

  logic clk;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  int   n      = 0;
  exp_t q[$];
  bit   hist[$];

  logic [7:0] glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] an_tbl [4]     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  segment_mux_if if0();
  segment_mux_if if1();

  segment_mux #(.DP_DIGIT(DP_DIGIT), .LZB(1'b0)) dut0 (
    .clk500hz (clk),
    .rstn     (rstn),
    .disp     (if0)
  );

  segment_mux #(.DP_DIGIT(DP_DIGIT), .LZB(1'b1)) dut1 (
    .clk500hz (clk),
    .rstn     (rstn),
    .disp     (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a digit shows its hex glyph unless blanking is on and the value
  // from that digit upward is zero; the dp of DP_DIGIT shows the blink level
  // as it was two scan edges earlier.
  function automatic logic [7:0] model_seg(input logic [15:0] v, input int slot,
                                           input bit lzb, input bit dp);
    logic [15:0] upper;
    logic [7:0]  s;
    upper = v >> (4 * slot);
    if (lzb && slot != 0 && upper == 16'h0) s = 8'hFF;
    else                                    s = glyph_tbl[upper[3:0]];
    if (slot == DP_DIGIT && dp) s[7] = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    n = 0;
    hist.delete();
  endtask

  // Apply one scan edge worth of input and queue what both instances must show
  task automatic step(input logic [15:0] v, input bit c);
    exp_t e;
    int   slot;
    bit   dp;
    @(negedge clk);
    if0.bcd_num = v;  if1.bcd_num = v;
    if0.CLK1Hz  = c;  if1.CLK1Hz  = c;
    hist.push_back(c);
    n++;
    slot = (n - 1) % 4;
    dp   = (hist.size() >= 3) ? hist[hist.size() - 3] : 1'b0;
    e.an   = an_tbl[slot];
    e.seg0 = model_seg(v, slot, 1'b0, dp);
    e.seg1 = model_seg(v, slot, 1'b1, dp);
    q.push_back(e);
  endtask

  // Monitor: after every edge out of reset, compare pins with the oldest prediction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rstn && q.size() > 0) begin
      e = q.pop_front();
      check("an_lzb0",  {4'h0, if0.an},  {4'h0, e.an});
      check("an_lzb1",  {4'h0, if1.an},  {4'h0, e.an});
      check("seg_lzb0", if0.segment, e.seg0);
      check("seg_lzb1", if1.segment, e.seg1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    bit          c;
    rstn = 1'b0;
    if0.bcd_num = 16'h0; if1.bcd_num = 16'h0;
    if0.CLK1Hz  = 1'b0;  if1.CLK1Hz  = 1'b0;

    // Reset held with the clock running
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_an",  {4'h0, if0.an}, 8'h0F);
      check("rst_seg", if1.segment, 8'hFF);
    end
    @(posedge clk); #3;
    rstn = 1'b1;
    model_reset();

    // Basic pattern, dp low then held high
    repeat (8)  step(16'h0123, 1'b0);
    repeat (12) step(16'h0123, 1'b1);
    // Leading zeros with a blinking dp
    c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i % 5 == 0) c = ~c;
      step(16'h0023, c);
    end
    repeat (8) step(16'hABEF, 1'b0);
    // Every glyph on every digit
    for (int h = 0; h < 16; h++) begin
      v = {4{4'(h)}};
      repeat (4) step(v, 1'b0);
    end
    // Randomized values with frequent leading zeros and sporadic blink changes
    c = 1'b0;
    for (int i = 0; i < 200; i++) begin
      v = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) c = ~c;
      step(v, c);
    end

    // Reset asserted while digit2 is lit
    while (((n - 1) % 4) != 2) step(16'h4567, 1'b1);
    @(posedge clk); #3;
    check("mid_an_before", {4'h0, if0.an}, 8'h0B);
    rstn = 1'b0;
    #1;
    check("mid_rst_an0",  {4'h0, if0.an}, 8'h0F);
    check("mid_rst_an1",  {4'h0, if1.an}, 8'h0F);
    check("mid_rst_seg0", if0.segment, 8'hFF);
    check("mid_rst_seg1", if1.segment, 8'hFF);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
    repeat (8) step(16'h4567, 1'b1);

    @(posedge clk); #2;
    check("queue_drained", 8'(q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
